// File: rtl/tx_packet_arbiter_pkg.sv
// Shared network package for the TX packet arbiter: default port count,
// beat widths, port-index width helper and the arbiter state encoding.
package tx_packet_arbiter_pkg;

  // Default number of AXI4-Stream sources feeding the MAC TX path.
  localparam int DEF_NUM_PORTS = 4;

  // Beat geometry of the 64-bit MAC datapath.
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  // Arbiter FSM states. IDLE doubles as the arbitration bubble between
  // packets, PASS is the cut-through forwarding phase.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_e;

  // Width of a port index. Never less than one bit so a two-port build
  // still has a real grant register.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_packet_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first requesting port found
// when searching upward from the port after last_grant, wrapping at NUM_PORTS.
module tx_packet_arbiter_rr_select
  import tx_packet_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int GW        = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        sel_idx,
  output logic                 sel_vld
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the final (winning) assignment; last_grant itself is
  // visited at offset NUM_PORTS and therefore has the lowest priority.
  always_comb begin
    int            p;
    logic [GW-1:0] p_idx;
    sel_idx = '0;
    sel_vld = 1'b0;
    p       = 0;
    p_idx   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      p     = (int'(last_grant) + k) % NUM_PORTS;
      p_idx = GW'(p);
      if (req[p_idx]) begin
        sel_idx = p_idx;
        sel_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI4-Stream sources into
// one stream toward the MAC TX interface.
//
// Handshake: a beat transfers on a port in any cycle where its tvalid and
// tready are both high at the rising edge of clk156; a source holds tvalid and
// its payload stable until that happens. The arbiter adds no storage, so the
// granted source sees m_axis_tready directly and the sink sees the granted
// source's payload directly. A whole packet (up to and including its tlast
// beat) is forwarded before another port can be granted, and one IDLE cycle
// separates consecutive packets while the next grant is chosen.
module tx_packet_arbiter
  import tx_packet_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  parameter  int CNT_WIDTH = 32,
  localparam int GW        = port_idx_w(NUM_PORTS)
) (
  input  logic                           clk156,
  input  logic                           aresetn,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  input  logic [NUM_PORTS*DATA_W-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_W-1:0]              m_axis_tdata,
  output logic [KEEP_W-1:0]              m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [GW-1:0]                  grant_port,
  output logic                           busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_count
);

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  logic [GW-1:0]        sel_idx;
  logic                 sel_vld;
  logic                 in_pass;
  logic                 g_valid;
  logic                 g_last;
  logic                 last_hs;

  // Next grant candidate, evaluated every cycle but only consumed in IDLE.
  tx_packet_arbiter_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_rr_select (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .sel_idx    (sel_idx),
    .sel_vld    (sel_vld)
  );

  // Forwarding is qualified by aresetn so nothing handshakes while reset is
  // held, even in the cycle before the state register clears.
  assign in_pass = aresetn && (state_q == ST_PASS);

  // Granted-port payload mux; payload is forwarded untouched (tkeep included).
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    g_valid      = 1'b0;
    g_last       = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        m_axis_tdata = s_axis_tdata[i*DATA_W +: DATA_W];
        m_axis_tkeep = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        g_valid      = s_axis_tvalid[i];
        g_last       = s_axis_tlast[i];
      end
    end
  end

  // Handshake routing: only the granted port sees the sink's ready, only in PASS.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_pass && (grant_q == GW'(i))) begin
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = in_pass & g_valid;
  assign m_axis_tlast  = g_last;
  assign busy          = in_pass;
  assign grant_port    = grant_q;
  assign last_hs       = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // FSM next state, grant bookkeeping and per-port packet counters.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        // Grant is held through source stalls and sink back-pressure; only
        // the tlast handshake releases it.
        if (last_hs) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == GW'(i)) begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_grant resets to the top port so port 0 wins first.
  always_ff @(posedge clk156) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten the counters onto the output bus, port i at slice i.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Bench for tx_packet_arbiter: queue-driven sources, packet-level round-robin
// reference model, beat scoreboard and protocol checks.
module tb_tx_packet_arbiter;

  localparam int NP = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [7:0]  gap;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] data;
  } beat_t;

  // clock / reset
  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;
  logic aresetn;

  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tready;
  logic [NP*64-1:0] s_axis_tdata;
  logic [NP*8-1:0]  s_axis_tkeep;
  logic [NP-1:0]    s_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic             m_axis_tlast;
  logic [1:0]       grant_port;
  logic             busy;
  logic [NP*CW-1:0] pkt_count;

  tx_packet_arbiter #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .clk156        (clk156),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .grant_port    (grant_port),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  // bench state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          seq     = 0;
  logic        rand_ready = 1'b0;
  beat_t       src_q [NP][$];
  int          wait_c [NP];
  logic [NP-1:0] hs_v = '0;
  logic [75:0] mdl_q [NP][$];
  logic [75:0] exp_q [$];
  int          mdl_cnt [NP];
  int          mdl_last = NP - 1;
  int          hs_cyc [$];
  logic        prev_last_hs = 1'b0;
  logic        prev_idle_req = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk156);
      #2;
    end
  endtask

  // Source drivers: pop on handshake, honour per-beat pre-gaps, random sink ready.
  always begin
    @(posedge clk156);
    cyc++;
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs_v[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) wait_c[i] = int'(src_q[i][0].gap);
      end else if (src_q[i].size() > 0 && wait_c[i] > 0) begin
        wait_c[i]--;
      end
    end
    hs_v = '0;
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0 && wait_c[i] == 0) begin
        s_axis_tvalid[i]        = 1'b1;
        s_axis_tdata[i*64 +: 64] = src_q[i][0].data;
        s_axis_tkeep[i*8 +: 8]   = src_q[i][0].keep;
        s_axis_tlast[i]         = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i]        = 1'b0;
        s_axis_tdata[i*64 +: 64] = '0;
        s_axis_tkeep[i*8 +: 8]   = '0;
        s_axis_tlast[i]         = 1'b0;
      end
    end
    m_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor + scoreboard, sampled mid-cycle.
  always begin
    logic [75:0]   e;
    logic [NP-1:0] er;
    logic [1:0]    ep;
    @(negedge clk156);
    if (aresetn) begin
      if (prev_last_hs) begin
        check("bubble_busy", 64'(busy), 64'd0);
        check("bubble_mvalid", 64'(m_axis_tvalid), 64'd0);
      end
      if (prev_idle_req) check("grant_latency", 64'(busy), 64'd1);
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("busy_no_pending_pkt", 64'd1, 64'd0);
        end else begin
          ep = exp_q[0][75:73];
          er = '0;
          if (m_axis_tready) er[ep] = 1'b1;
          check("grant_port", 64'(grant_port), 64'(ep));
          check("sready_route", 64'(s_axis_tready), 64'(er));
        end
      end else begin
        check("idle_sready", 64'(s_axis_tready), 64'd0);
        check("idle_mvalid", 64'(m_axis_tvalid), 64'd0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_axis_tdata, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e[63:0]);
          check("beat_keep", 64'(m_axis_tkeep), 64'(e[71:64]));
          check("beat_last", 64'(m_axis_tlast), 64'(e[72]));
        end
      end
    end else begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_sready", 64'(s_axis_tready), 64'd0);
    end
    hs_v          = s_axis_tvalid & s_axis_tready;
    prev_last_hs  = aresetn && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    prev_idle_req = aresetn && !busy && (|s_axis_tvalid);
  end

  // Queue one packet on a source and in the model's per-port backlog.
  task automatic add_pkt(input int p, input int nb, input int gmax, input int g1);
    beat_t       b;
    logic [2:0]  pp;
    pp = p[2:0];
    for (int k = 0; k < nb; k++) begin
      b.gap  = (k == 0) ? 8'd0 : ((k == 1 && g1 >= 0) ? 8'(g1) : 8'($urandom_range(0, gmax)));
      b.keep = 8'($urandom);
      b.last = (k == nb - 1);
      b.data = {8'(p), 16'(seq), 8'(k), 32'($urandom)};
      src_q[p].push_back(b);
      mdl_q[p].push_back({pp, b.last, b.keep, b.data});
    end
    seq++;
  endtask

  // Reference: whole packets leave in round-robin order among ports with backlog.
  task automatic model_run();
    int          p;
    logic [75:0] bt;
    while (1) begin
      p = -1;
      for (int k = 1; k <= NP; k++) begin
        if (p < 0 && mdl_q[(mdl_last + k) % NP].size() > 0) p = (mdl_last + k) % NP;
      end
      if (p < 0) break;
      do begin
        bt = mdl_q[p].pop_front();
        exp_q.push_back(bt);
      end while (!bt[72]);
      mdl_cnt[p] = (mdl_cnt[p] + 1) % (1 << CW);
      mdl_last   = p;
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      wait_c[i]  = 0;
      mdl_cnt[i] = 0;
    end
    exp_q.delete();
    mdl_last = NP - 1;
  endtask

  task automatic reset_begin();
    aresetn = 1'b0;
    flush_all();
  endtask

  function automatic logic pending();
    logic r;
    r = (exp_q.size() > 0);
    for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick(1);
      n++;
    end
    if (pending()) begin
      check("drain_timeout", 64'd1, 64'd0);
      flush_all();
    end
    tick(2);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < NP; i++) check(tag, 64'(pkt_count[i*CW +: CW]), 64'(mdl_cnt[i]));
  endtask

  task automatic check_reset_state();
    @(negedge clk156);
    check("rst_grant_port", 64'(grant_port), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    tick(1);
  endtask

  initial begin
    int t0;
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;

    // Reset with every port requesting: port 0 goes first.
    reset_begin();
    tick(2);
    check_reset_state();
    for (int i = 0; i < NP; i++) add_pkt(i, 2, 0, -1);
    model_run();
    tick(2);
    aresetn = 1'b1;
    drain(500);
    check_counts("cnt_first_round");

    // Continuous 3-beat packets on all ports: strict rotation, one bubble each.
    reset_begin();
    tick(2);
    aresetn = 1'b1;
    hs_cyc.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NP; i++) add_pkt(i, 3, 0, -1);
    model_run();
    drain(500);
    check("rr_span", 64'(hs_cyc[$] - hs_cyc[0]), 64'd30);
    check_counts("cnt_rr");

    // Port 2 alone, single-beat packets back to back: one beat every 2 cycles.
    hs_cyc.delete();
    for (int k = 0; k < 6; k++) add_pkt(2, 1, 0, -1);
    model_run();
    drain(500);
    check("single_beat_count", 64'(hs_cyc.size()), 64'd6);
    for (int k = 1; k < hs_cyc.size(); k++) check("single_beat_spacing", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd2);
    check_counts("cnt_single");

    // Port 1 stalls 5 cycles mid-packet while port 3 waits.
    reset_begin();
    tick(2);
    aresetn = 1'b1;
    add_pkt(1, 4, 0, 5);
    add_pkt(3, 2, 0, -1);
    model_run();
    drain(500);
    check_counts("cnt_stall");

    // 17 packets through a 4-bit counter wrap it to 1.
    reset_begin();
    tick(2);
    aresetn = 1'b1;
    for (int k = 0; k < 17; k++) add_pkt(0, 1, 0, -1);
    model_run();
    drain(1000);
    check("cnt_wrap", 64'(pkt_count[CW-1:0]), 64'd1);
    check_counts("cnt_wrap_all");

    // 100 mixed packets with source gaps and random sink back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) add_pkt($urandom_range(0, NP-1), $urandom_range(1, 6), 3, -1);
    model_run();
    drain(20000);
    check_counts("cnt_random");
    rand_ready = 1'b0;
    tick(2);

    // Reset pulsed in the middle of a packet.
    add_pkt(1, 8, 0, -1);
    model_run();
    t0 = 0;
    while (!busy && t0 < 50) begin
      tick(1);
      t0++;
    end
    check("busy_before_abort", 64'(busy), 64'd1);
    tick(2);
    reset_begin();
    tick(1);
    aresetn = 1'b1;
    @(negedge clk156);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_counts", 64'(pkt_count), 64'd0);
    check("abort_grant", 64'(grant_port), 64'd0);
    tick(3);
    check("abort_stays_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 900000ns");
    $fatal(1, "watchdog");
  end

endmodule
